// File: rtl/sprf_addr_gen.sv
// sprf_addr_gen: pointer register file producing registered indirect dmem addresses
// with per-pointer base/limit circular post-increment.
module sprf_addr_gen #(
    parameter int ADDR_W   = 16,
    parameter int NPTR     = 4,
    parameter int IDX_W    = 2,
    parameter int STRIDE_W = 4
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                t_cs,
    input  logic                ipt_ld_en,
    input  logic                ipt_lim_en,
    input  logic [IDX_W-1:0]    ipt_ld_idx,
    input  logic [ADDR_W-1:0]   ipt_ld_data,
    input  logic                ipt_rd_en,
    input  logic [IDX_W-1:0]    ipt_rd_idx,
    input  logic                ipt_inc_en,
    input  logic [STRIDE_W-1:0] ipt_stride,
    output logic [ADDR_W-1:0]   opt_addr,
    output logic                opt_addr_vld,
    output logic                opt_wrap,
    output logic                opt_err
);
    logic [ADDR_W-1:0] ptr  [NPTR];
    logic [ADDR_W-1:0] base [NPTR];
    logic [ADDR_W-1:0] lim  [NPTR];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   sum;
    logic              fwd;
    logic              inc;
    logic              wrap;

    // Sum carries one extra bit so a carry-out always counts as exceeding the limit.
    always_comb begin
        rd_ptr = ptr[ipt_rd_idx];
        sum    = {1'b0, rd_ptr} + {{(ADDR_W+1-STRIDE_W){1'b0}}, ipt_stride};
        fwd    = ipt_ld_en && (ipt_ld_idx == ipt_rd_idx);
        inc    = ipt_rd_en && ipt_inc_en && !fwd;
        wrap   = sum > {1'b0, lim[ipt_rd_idx]};
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NPTR; i++) begin
                ptr[i]  <= '0;
                base[i] <= '0;
                lim[i]  <= '1;
            end
            opt_addr     <= '0;
            opt_addr_vld <= 1'b0;
            opt_wrap     <= 1'b0;
            opt_err      <= 1'b0;
        end else if (t_cs) begin
            opt_addr_vld <= ipt_rd_en;
            opt_wrap     <= inc && wrap;
            if (ipt_rd_en)
                opt_addr <= fwd ? ipt_ld_data : rd_ptr;
            if (inc)
                ptr[ipt_rd_idx] <= wrap ? base[ipt_rd_idx] : sum[ADDR_W-1:0];
            // A pointer load takes priority over a limit write on the same cycle.
            if (ipt_ld_en) begin
                ptr[ipt_ld_idx]  <= ipt_ld_data;
                base[ipt_ld_idx] <= ipt_ld_data;
            end else if (ipt_lim_en) begin
                lim[ipt_ld_idx] <= ipt_ld_data;
            end
            if (ipt_ld_en && ipt_lim_en)
                opt_err <= 1'b1;
        end else begin
            opt_addr_vld <= 1'b0;
            opt_wrap     <= 1'b0;
        end
    end
endmodule
